// File: rtl/rvga_types.sv
// Shared types for the rvga memory subsystem: word type and arbiter FSM states.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        StIdle,
        StIfetch,
        StDaccess
    } rvga_arb_state_e;

endpackage

// File: rtl/rvga_mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one shared memory port.
// Requests are granted from idle only, and the captured transaction runs to completion.
module rvga_mem_arbiter
    import rvga_types::*;
#(
    parameter int unsigned DMEM_PRIO = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,

    input  logic     imem_v_i,
    input  rvga_word imem_addr_i,
    output rvga_word imem_data_o,
    output logic     imem_resp_v_o,

    input  logic     dmem_r_v_i,
    input  logic     dmem_w_v_i,
    input  rvga_word dmem_addr_i,
    input  rvga_word dmem_data_i,
    output rvga_word dmem_data_o,
    output logic     dmem_resp_v_o,

    output logic     mem_r_v_o,
    output logic     mem_w_v_o,
    output rvga_word mem_addr_o,
    output rvga_word mem_data_o,
    input  rvga_word mem_data_i,
    input  logic     mem_resp_v_i
);

    rvga_arb_state_e state_q, state_d;
    rvga_word        addr_q;
    rvga_word        data_q;
    logic            wr_q;
    logic            last_data_q;

    logic dmem_req;
    logic prio_data;
    logic grant_data;

    assign dmem_req  = dmem_r_v_i | dmem_w_v_i;
    assign prio_data = (DMEM_PRIO != 0);
    // Under round-robin, data only wins contention if the fetch side was granted last.
    assign grant_data = dmem_req & (~imem_v_i | prio_data | ~last_data_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    state_d = StDaccess;
                end else if (imem_v_i) begin
                    state_d = StIfetch;
                end
            end
            StIfetch, StDaccess: begin
                if (mem_resp_v_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_r_v_o     = 1'b0;
        mem_w_v_o     = 1'b0;
        imem_resp_v_o = 1'b0;
        dmem_resp_v_o = 1'b0;
        unique case (state_q)
            StIfetch: begin
                mem_r_v_o     = 1'b1;
                // A dropped request is a flush: the port completes but no pulse is sent.
                imem_resp_v_o = mem_resp_v_i & imem_v_i;
            end
            StDaccess: begin
                mem_w_v_o     = wr_q;
                mem_r_v_o     = ~wr_q;
                dmem_resp_v_o = mem_resp_v_i & dmem_req;
            end
            default: ;
        endcase
    end

    // Capture on grant; a simultaneous read+write is treated as a write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            last_data_q <= 1'b1;
        end else if (state_q == StIdle) begin
            if (grant_data) begin
                addr_q      <= dmem_addr_i;
                data_q      <= dmem_data_i;
                wr_q        <= dmem_w_v_i;
                last_data_q <= 1'b1;
            end else if (imem_v_i) begin
                addr_q      <= imem_addr_i;
                data_q      <= '0;
                wr_q        <= 1'b0;
                last_data_q <= 1'b0;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign imem_data_o = mem_data_i;
    assign dmem_data_o = mem_data_i;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter: one instance with data priority, one round-robin.
module tb_rvga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_v;
    logic [31:0] imem_addr;
    logic        dmem_r_v, dmem_w_v;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic [31:0] p1_imem_data, p1_dmem_data, p1_mem_addr, p1_mem_data;
    logic        p1_imem_resp, p1_dmem_resp, p1_mem_r_v, p1_mem_w_v;
    logic [31:0] p0_imem_data, p0_dmem_data, p0_mem_addr, p0_mem_data;
    logic        p0_imem_resp, p0_dmem_resp, p0_mem_r_v, p0_mem_w_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rvga_mem_arbiter #(.DMEM_PRIO(1)) dut_p1 (
        .clk_i(clk), .rst_i(rst_n),
        .imem_v_i(imem_v), .imem_addr_i(imem_addr),
        .imem_data_o(p1_imem_data), .imem_resp_v_o(p1_imem_resp),
        .dmem_r_v_i(dmem_r_v), .dmem_w_v_i(dmem_w_v),
        .dmem_addr_i(dmem_addr), .dmem_data_i(dmem_wdata),
        .dmem_data_o(p1_dmem_data), .dmem_resp_v_o(p1_dmem_resp),
        .mem_r_v_o(p1_mem_r_v), .mem_w_v_o(p1_mem_w_v),
        .mem_addr_o(p1_mem_addr), .mem_data_o(p1_mem_data),
        .mem_data_i(mem_rdata), .mem_resp_v_i(mem_resp)
    );

    rvga_mem_arbiter #(.DMEM_PRIO(0)) dut_p0 (
        .clk_i(clk), .rst_i(rst_n),
        .imem_v_i(imem_v), .imem_addr_i(imem_addr),
        .imem_data_o(p0_imem_data), .imem_resp_v_o(p0_imem_resp),
        .dmem_r_v_i(dmem_r_v), .dmem_w_v_i(dmem_w_v),
        .dmem_addr_i(dmem_addr), .dmem_data_i(dmem_wdata),
        .dmem_data_o(p0_dmem_data), .dmem_resp_v_o(p0_dmem_resp),
        .mem_r_v_o(p0_mem_r_v), .mem_w_v_o(p0_mem_w_v),
        .mem_addr_o(p0_mem_addr), .mem_data_o(p0_mem_data),
        .mem_data_i(mem_rdata), .mem_resp_v_i(mem_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_v = 1'b0; imem_addr = '0;
        dmem_r_v = 1'b0; dmem_w_v = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        mem_rdata = 32'hA5A5_0001;
        #3;
        checks++;
        if ({p1_mem_r_v, p1_mem_w_v, p1_imem_resp, p1_dmem_resp} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_p1_strobes got=%b exp=0000",
                     {p1_mem_r_v, p1_mem_w_v, p1_imem_resp, p1_dmem_resp});
        end
        checks++;
        if (p1_mem_addr !== 32'h0 || p1_mem_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_p1_addr_data got=%h/%h exp=0/0", p1_mem_addr, p1_mem_data);
        end
        checks++;
        if ({p0_mem_r_v, p0_mem_w_v, p0_imem_resp, p0_dmem_resp} !== 4'b0000 ||
            p0_mem_addr !== 32'h0 || p0_mem_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_p0_outputs got=%b %h %h exp=0000 0 0",
                     {p0_mem_r_v, p0_mem_w_v, p0_imem_resp, p0_dmem_resp},
                     p0_mem_addr, p0_mem_data);
        end
        checks++;
        if (p1_imem_data !== 32'hA5A5_0001 || p0_dmem_data !== 32'hA5A5_0001 ||
            p1_dmem_data !== 32'hA5A5_0001 || p0_imem_data !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL reset_data_passthru got=%h exp=a5a50001", p1_imem_data);
        end
        do_reset();
    endtask

    task automatic test_ifetch();
        imem_v = 1'b1; imem_addr = 32'h100;
        #1;
        checks++;
        if (p1_mem_r_v !== 1'b0) begin
            failures++;
            $display("FAIL ifetch_no_comb_strobe got=%b exp=0", p1_mem_r_v);
        end
        tick();
        checks++;
        if (p1_mem_r_v !== 1'b1 || p1_mem_w_v !== 1'b0 || p1_mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL ifetch_strobe got=r%b w%b a=%h exp=r1 w0 a=100",
                     p1_mem_r_v, p1_mem_w_v, p1_mem_addr);
        end
        tick(); tick(); tick();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        checks++;
        if (p1_imem_resp !== 1'b1 || p1_imem_data !== 32'h13 || p1_dmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL ifetch_resp got=i%b d=%h dr%b exp=i1 d=00000013 dr0",
                     p1_imem_resp, p1_imem_data, p1_dmem_resp);
        end
        tick();
        mem_resp = 1'b0; imem_v = 1'b0;
        #1;
        checks++;
        if (p1_mem_r_v !== 1'b0 || p1_imem_resp !== 1'b0) begin
            failures++;
            $display("FAIL ifetch_done got=r%b i%b exp=r0 i0", p1_mem_r_v, p1_imem_resp);
        end
        tick();
    endtask

    task automatic test_dmem_prio();
        dmem_w_v = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'hDEAD_BEEF;
        imem_v = 1'b1; imem_addr = 32'h300;
        tick();
        dmem_addr = 32'h5555; dmem_wdata = 32'h0;
        #1;
        checks++;
        if (p1_mem_w_v !== 1'b1 || p1_mem_r_v !== 1'b0 ||
            p1_mem_addr !== 32'h2000 || p1_mem_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL prio_write got=w%b r%b a=%h d=%h exp=w1 r0 a=2000 d=deadbeef",
                     p1_mem_w_v, p1_mem_r_v, p1_mem_addr, p1_mem_data);
        end
        tick();
        mem_resp = 1'b1;
        #1;
        checks++;
        if (p1_dmem_resp !== 1'b1 || p1_imem_resp !== 1'b0) begin
            failures++;
            $display("FAIL prio_write_resp got=d%b i%b exp=d1 i0", p1_dmem_resp, p1_imem_resp);
        end
        tick();
        mem_resp = 1'b0; dmem_w_v = 1'b0;
        #1;
        checks++;
        if (p1_mem_r_v !== 1'b0 || p1_mem_w_v !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_gap got=r%b w%b exp=r0 w0", p1_mem_r_v, p1_mem_w_v);
        end
        tick();
        checks++;
        if (p1_mem_r_v !== 1'b1 || p1_mem_w_v !== 1'b0 || p1_mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL prio_fetch_after got=r%b w%b a=%h exp=r1 w0 a=300",
                     p1_mem_r_v, p1_mem_w_v, p1_mem_addr);
        end
        mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (p1_imem_resp !== 1'b1 || p1_dmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL prio_fetch_resp got=i%b d%b exp=i1 d0", p1_imem_resp, p1_dmem_resp);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_rw_conflict();
        dmem_r_v = 1'b1; dmem_w_v = 1'b1; dmem_addr = 32'h700; dmem_wdata = 32'h77;
        tick();
        checks++;
        if (p1_mem_w_v !== 1'b1 || p1_mem_r_v !== 1'b0) begin
            failures++;
            $display("FAIL rw_conflict got=w%b r%b exp=w1 r0", p1_mem_w_v, p1_mem_r_v);
        end
        mem_resp = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_i;
        do_reset();
        imem_v = 1'b1; imem_addr = 32'h400;
        dmem_r_v = 1'b1; dmem_addr = 32'h800;
        exp_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int n = 0;
            while (!(p0_mem_r_v | p0_mem_w_v) && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 10) begin
                failures++;
                $display("FAIL rr_timeout txn=%0d got=no strobe exp=strobe", t);
            end
            checks++;
            if (p0_mem_addr !== (exp_i ? 32'h400 : 32'h800)) begin
                failures++;
                $display("FAIL rr_grant txn=%0d got=%h exp=%h", t, p0_mem_addr,
                         exp_i ? 32'h400 : 32'h800);
            end
            mem_resp = 1'b1; mem_rdata = 32'hC0DE_0000 + t;
            #1;
            checks++;
            if (p0_imem_resp !== exp_i || p0_dmem_resp !== ~exp_i ||
                p0_imem_data !== 32'hC0DE_0000 + t) begin
                failures++;
                $display("FAIL rr_resp txn=%0d got=i%b d%b data=%h exp=i%b d%b", t,
                         p0_imem_resp, p0_dmem_resp, p0_imem_data, exp_i, ~exp_i);
            end
            tick();
            mem_resp = 1'b0;
            exp_i = ~exp_i;
        end
        do_reset();
    endtask

    task automatic test_flush();
        imem_v = 1'b1; imem_addr = 32'h500;
        tick();
        imem_v = 1'b0;
        checks++;
        if (p1_mem_r_v !== 1'b1) begin
            failures++;
            $display("FAIL flush_grant got=%b exp=1", p1_mem_r_v);
        end
        tick();
        checks++;
        if (p1_mem_r_v !== 1'b1 || p1_mem_addr !== 32'h500) begin
            failures++;
            $display("FAIL flush_held got=r%b a=%h exp=r1 a=500", p1_mem_r_v, p1_mem_addr);
        end
        tick();
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_0000;
        #1;
        checks++;
        if (p1_imem_resp !== 1'b0 || p1_mem_r_v !== 1'b1) begin
            failures++;
            $display("FAIL flush_no_resp got=i%b r%b exp=i0 r1", p1_imem_resp, p1_mem_r_v);
        end
        tick();
        mem_resp = 1'b0;
        tick();
        checks++;
        if (p1_mem_r_v !== 1'b0 || p1_mem_w_v !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle got=r%b w%b exp=r0 w0", p1_mem_r_v, p1_mem_w_v);
        end
    endtask

    task automatic test_reset_mid();
        dmem_r_v = 1'b1; dmem_addr = 32'h600;
        tick();
        checks++;
        if (p1_mem_r_v !== 1'b1 || p1_mem_addr !== 32'h600) begin
            failures++;
            $display("FAIL rstmid_grant got=r%b a=%h exp=r1 a=600", p1_mem_r_v, p1_mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p1_mem_r_v, p1_mem_w_v, p1_dmem_resp, p1_imem_resp} !== 4'b0000 ||
            p1_mem_addr !== 32'h0 || p1_mem_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b a=%h exp=0000 a=0",
                     {p1_mem_r_v, p1_mem_w_v, p1_dmem_resp, p1_imem_resp}, p1_mem_addr);
        end
        dmem_r_v = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        mem_resp = 1'b1;
        #1;
        checks++;
        if (p1_dmem_resp !== 1'b0 || p1_mem_r_v !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_stray got=d%b r%b exp=d0 r0", p1_dmem_resp, p1_mem_r_v);
        end
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic test_idle_resp();
        clear_inputs();
        mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (p1_imem_resp !== 1'b0 || p1_dmem_resp !== 1'b0 ||
            p0_imem_resp !== 1'b0 || p0_dmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL idle_resp_pulse got=%b%b%b%b exp=0000",
                     p1_imem_resp, p1_dmem_resp, p0_imem_resp, p0_dmem_resp);
        end
        tick();
        tick();
        checks++;
        if (p1_mem_r_v !== 1'b0 || p1_mem_w_v !== 1'b0 || p1_mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL idle_resp_state got=r%b w%b a=%h exp=r0 w0 a=0",
                     p1_mem_r_v, p1_mem_w_v, p1_mem_addr);
        end
        mem_resp = 1'b0;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_ifetch();
        test_dmem_prio();
        test_rw_conflict();
        test_round_robin();
        test_flush();
        test_reset_mid();
        test_idle_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvga_mem_arbiter.md
RVGA_MEM_ARBITER -- requirements
Module: rvga_mem_arbiter

Interface
REQ-001 Parameter: DMEM_PRIO, default 1, 1 = data requests always win contention; 0 = round-robin between instruction and data.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 imem_v_i  input  1  instruction fetch request, held until imem_resp_v_o.
REQ-005 imem_addr_i  input  32 (rvga_word)  fetch address.
REQ-006 imem_data_o  output  32  fetched instruction, valid with imem_resp_v_o.
REQ-007 imem_resp_v_o  output  1  one-cycle fetch completion pulse.
REQ-008 dmem_r_v_i / dmem_w_v_i  input  1 each  data read / write request, held until dmem_resp_v_o.
REQ-009 dmem_addr_i  input  32  data address; dmem_data_i  input  32  write data.
REQ-010 dmem_data_o  output  32  read data, valid with dmem_resp_v_o; dmem_resp_v_o  output  1  one-cycle completion pulse.
REQ-011 mem_r_v_o / mem_w_v_o  output  1 each  shared-port read / write strobe, level, held until mem_resp_v_i.
REQ-012 mem_addr_o  output  32; mem_data_o  output  32  shared-port address and write data.
REQ-013 mem_data_i  input  32; mem_resp_v_i  input  1  shared-port read data and one-cycle completion.

Function
REQ-014 FSM states IDLE, IFETCH, DACCESS; exactly one state active at any time.
REQ-015 IDLE: only dmem request -> DACCESS; only imem request -> IFETCH; none -> stay IDLE.
REQ-016 IDLE, both pending: DMEM_PRIO=1 -> DACCESS; DMEM_PRIO=0 -> grant the side not granted last (last-grant flag resets to data, so first contention goes to IFETCH).
REQ-017 On grant, address, write data and read/write kind are captured into registers; mem_* outputs driven only from those registers.
REQ-018 Latency: request seen in IDLE at edge N -> mem_r_v_o/mem_w_v_o high from cycle N+1.
REQ-019 IFETCH drives mem_r_v_o=1, mem_w_v_o=0; DACCESS drives mem_w_v_o=1 for writes, mem_r_v_o=1 for reads, never both.
REQ-020 dmem_r_v_i and dmem_w_v_i both high at grant is a protocol error; the write is performed, the read ignored.
REQ-021 imem_data_o and dmem_data_o are combinational copies of mem_data_i; the resp pulse is asserted in the same cycle as mem_resp_v_i, only to the granted side.
REQ-022 On mem_resp_v_i in IFETCH/DACCESS: next state IDLE, strobes low the following cycle; minimum one IDLE cycle between transactions.
REQ-023 mem_resp_v_i in IDLE is ignored; no resp pulse generated.
REQ-024 Granted request deasserted before mem_resp_v_i (flush): transaction still runs to completion on the shared port; its resp pulse is suppressed.
REQ-025 Requester input changes after grant do not affect mem_addr_o/mem_data_o.
REQ-026 The non-granted requester waits with no resp; its request is not lost while held.

Reset
REQ-027 While rst_i=0: state IDLE, mem_r_v_o=0, mem_w_v_o=0, mem_addr_o=0, mem_data_o=0, imem_resp_v_o=0, dmem_resp_v_o=0, last-grant=data.
REQ-028 Reset mid-transaction abandons it immediately; a late mem_resp_v_i after reset release is ignored per REQ-023.

Structure
REQ-029 State enum rvga_arb_state_e (IDLE, IFETCH, DACCESS) added to the shared rvga_types package; rvga_word used for all 32-bit ports.
REQ-030 Single flat module, no sub-module; FSM register, capture registers, last-grant flag only.

Verification
REQ-031 imem_v_i=1 addr 0x100, mem responds 3 cycles after strobe with 0x00000013 -> mem_r_v_o high one cycle after request, imem_resp_v_o pulses once with imem_data_o=0x00000013.
REQ-032 dmem_w_v_i=1 addr 0x2000 data 0xDEADBEEF, imem_v_i=1 same cycle, DMEM_PRIO=1 -> write issued first with captured values, fetch issued after one IDLE cycle.
REQ-033 DMEM_PRIO=0, both requests held continuously for 4 transactions -> grants alternate I, D, I, D.
REQ-034 Grant fetch, drop imem_v_i next cycle, respond 2 cycles later -> mem_r_v_o held until response, no imem_resp_v_o, FSM back in IDLE.
REQ-035 rst_i low during DACCESS, then stray mem_resp_v_i after release -> all outputs 0 during reset, no dmem_resp_v_o pulse.
REQ-036 mem_resp_v_i asserted while IDLE with no requests -> no resp pulse, outputs unchanged.
